spi_req_arbiter: RTL and testbench
==================================

# spi_req_arbiter

Round-robin arbiter and sequencer that shares one `spi_master`/`spi_slave` link between `NREQ` client requesters. It sits between the clients and the `top` SPI datapath. It grants one client at a time, drives that client's word onto `newd`/`din`, and holds `newd` long enough for the slow `sclk` domain to sample it. It then waits for the link's `done`, synchronizes it, and returns a one-cycle acknowledge to the granted client.

## Interface
- `NREQ`, 4: number of requesters; 2..8.
- `DW`, 12: SPI word width; matches `din`/`dout`.
- `NEWD_HOLD`, 48: clk cycles `spi_newd` is held high; must be at least 2 full `sclk` periods (2×22 = 44 clk).
- `TIMEOUT`, 4096: clk cycles allowed in WAIT before abort. Used only with `SPI_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; same clock as `top.clk`.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-client request level.
- `req_data`  in  NREQ*DW  client words; client i uses bits [i*DW +: DW].
- `gnt`  out  NREQ  one-hot grant; held for the whole transaction.
- `ack`  out  NREQ  one-cycle completion pulse to the granted client.
- `spi_newd`  out  1  to `top.newd`.
- `spi_din`  out  DW  to `top.din`; registered.
- `spi_done`  in  1  from `top.done`; `sclk`-derived, asynchronous to this block's logic.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse coincident with `ack` on an aborted transaction.

## Operation
- Reset values: `gnt`=0, `ack`=0, `spi_newd`=0, `spi_din`=0, `busy`=0, `timeout_err`=0. Round-robin pointer=0, state=IDLE, synchronizer flops=0.
- IDLE:
  - The arbiter searches `req` starting at the pointer, upward, wrapping at NREQ-1→0. The first set bit wins.
  - On a winner k: latch `req_data[k]` into `spi_din`, set `gnt[k]` and `spi_newd`, clear the hold counter, go to LAUNCH.
  - With no request, the state stays IDLE and the pointer is unchanged.
- LAUNCH:
  - The hold counter increments each cycle.
  - When the count reaches NEWD_HOLD-1: drop `spi_newd` and go to WAIT.
- WAIT:
  - `spi_done` passes through a 2-flop synchronizer and rising-edge detect.
  - On a detected rise, go to COMPLETE.
  - Any `done` rise seen during LAUNCH is ignored; the edge detector is armed only in WAIT.
- COMPLETE (one cycle):
  - Pulse `ack[k]`, clear `gnt`, set pointer = (k+1) mod NREQ, go to IDLE.
- Client rules:
  - Hold `req[k]` and `req_data[k]` stable until `ack[k]`.
  - Data is sampled only at grant, so later changes to `req_data[k]` are ignored.
  - If `req[k]` falls mid-transaction, the transaction still completes and `ack[k]` still pulses.
  - If `req[k]` is still high in the cycle after `ack[k]`, it is treated as a new request at the lowest rotated priority.
- Simultaneous requests: exactly one grant, chosen by the pointer. Other requesters wait with no starvation; worst-case wait is NREQ-1 transactions.
- `spi_din` holds its value after completion until the next grant.

## Timing
- `req[k]` high at edge t in IDLE → `gnt[k]`, `spi_newd`, `spi_din` valid after edge t+1.
- `spi_newd` is high for exactly NEWD_HOLD cycles.
- `spi_done` rise → `ack` after 3 edges: 2 for synchronization, 1 for edge detection/state transition.
- Back-to-back transactions:
  - Minimum IDLE→IDLE cycle is NEWD_HOLD + 4 cycles plus link latency.
  - The next grant can occur the cycle after COMPLETE.
- `rst` asserted in any state returns every output to its reset value immediately; no `ack` is issued for the aborted transfer.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If no `done` rise arrives within TIMEOUT cycles, go to COMPLETE: pulse `ack[k]` together with `timeout_err`, and advance the pointer normally.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - No counter is built; WAIT persists indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Single request: `req`=4'b0001, `req_data[0]`=12'hA5C → `gnt`=0001 next cycle, `spi_newd` high 48 cycles, link `dout`=12'hA5C, one `ack[0]` pulse, `busy` low after.
- All four request together with data 12'h111/222/333/444 held → grants in order 0,1,2,3; `dout` sequence 111,222,333,444; each `ack` exactly once.
- Pointer fairness: after serving client 2, assert `req`=1111 → next grant is client 3, then 0.
- Request dropped mid-transaction: client 1 granted, `req[1]` low during WAIT → transfer completes, `ack[1]` pulses, no regrant.
- Reset mid-transfer: assert `rst` during LAUNCH → all outputs 0 within the same cycle, no `ack`; after release, `req[0]` is granted first.
- With `SPI_ARB_TIMEOUT_EN`, TIMEOUT=100, `spi_done` forced 0 → `ack[k]` and `timeout_err` pulse together 100 cycles after entering WAIT, then IDLE.

Source files
------------

// File: rtl/spi_req_arbiter_if.sv
// Client request/grant bundle plus the SPI link hooks for spi_req_arbiter.
// The slave modport is the arbiter side; master is the client/link side.
interface spi_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 12
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               spi_newd;
    logic [DW-1:0]      spi_din;
    logic               spi_done;
    logic               busy;
    logic               timeout_err;

    modport master (
        output req,
        output req_data,
        output spi_done,
        input  gnt,
        input  ack,
        input  spi_newd,
        input  spi_din,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  req,
        input  req_data,
        input  spi_done,
        output gnt,
        output ack,
        output spi_newd,
        output spi_din,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI link among NREQ clients.
// Optional WAIT-state abort counter is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_req_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 12,
    parameter int NEWD_HOLD = 48,
    parameter int TIMEOUT   = 4096
) (
    input logic              clk,
    input logic              rst,
    spi_req_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (NEWD_HOLD > 1) ? $clog2(NEWD_HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   cur;
    logic [PW-1:0]   win;
    logic            win_vld;
    logic [DW-1:0]   win_data;
    logic [DW-1:0]   din_q;
    logic [HW-1:0]   hold_cnt;
    logic            hold_last;
    logic [NREQ-1:0] cur_oh;
    logic            sync1;
    logic            sync2;
    logic            done_q;
    logic            done_rise;
    logic            to_hit;
    logic            to_flag;

    // First requester at or above the pointer, wrapping; lowest offset wins.
    always_comb begin
        logic [PW:0] j;
        win     = '0;
        win_vld = 1'b0;
        j       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = {1'b0, ptr} + (PW+1)'(i);
            if (j >= (PW+1)'(NREQ)) begin
                j = j - (PW+1)'(NREQ);
            end
            if (bus.req[j[PW-1:0]]) begin
                win     = j[PW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign win_data  = bus.req_data[int'(win)*DW +: DW];
    assign hold_last = (hold_cnt == HW'(NEWD_HOLD - 1));
    assign cur_oh    = {{(NREQ-1){1'b0}}, 1'b1} << cur;

    // spi_done comes from the sclk domain: two flops, then edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sync1  <= bus.spi_done;
            sync2  <= sync1;
            done_q <= sync2;
        end
    end

    assign done_rise = sync2 & ~done_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;

    assign to_hit = (state == S_WAIT) && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            // A genuine done rise on the final cycle still counts as success.
            to_flag <= to_hit && !done_rise;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign to_hit         = 1'b0;
    assign to_flag        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (hold_last) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_rise || to_hit) begin
                    state_nx = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            cur      <= '0;
            din_q    <= '0;
            hold_cnt <= '0;
        end else begin
            if (state == S_IDLE && win_vld) begin
                cur      <= win;
                din_q    <= win_data;
                hold_cnt <= '0;
            end
            if (state == S_LAUNCH) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state == S_COMPLETE) begin
                ptr <= (cur == PW'(NREQ - 1)) ? '0 : cur + 1'b1;
            end
        end
    end

    assign bus.spi_din = din_q;

    always_comb begin
        bus.gnt         = '0;
        bus.ack         = '0;
        bus.spi_newd    = 1'b0;
        bus.busy        = 1'b0;
        bus.timeout_err = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
            end
            S_LAUNCH: begin
                bus.gnt      = cur_oh;
                bus.spi_newd = 1'b1;
                bus.busy     = 1'b1;
            end
            S_WAIT: begin
                bus.gnt  = cur_oh;
                bus.busy = 1'b1;
            end
            S_COMPLETE: begin
                bus.gnt         = cur_oh;
                bus.ack         = cur_oh;
                bus.busy        = 1'b1;
                bus.timeout_err = to_flag;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: directed steps plus random traffic
// checked against a round-robin reference model and the link timing rules.
module tb_spi_req_arbiter;
    localparam int NREQ      = 4;
    localparam int DW        = 12;
    localparam int NEWD_HOLD = 48;
    localparam int TIMEOUT   = 100;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_req_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    spi_req_arbiter #(
        .NREQ(NREQ),
        .DW(DW),
        .NEWD_HOLD(NEWD_HOLD),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int            n_chk  = 0;
    int            n_fail = 0;
    int            mptr   = 0;
    logic [DW-1:0] data [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i*DW +: DW] = data[i];
        end
    endtask

    // Reference: first requesting client scanning upward from the pointer.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // Called at a negedge in IDLE with at least one request pending.
    task automatic txn(input int lat, input bit drop_mid, input bit early,
                       output int k);
        int            cnt;
        bit            bad;
        logic [DW-1:0] word;
        k    = pick(bus.req, mptr);
        word = data[k];
        bad  = 1'b0;
        @(negedge clk);
        chk("grant", bus.gnt, 32'(1) << k);
        chk("newd_rise", bus.spi_newd, 1);
        chk("din_at_grant", bus.spi_din, word);
        chk("busy_on", bus.busy, 1);
        data[k] = DW'($urandom);
        drive_data();
        cnt = 0;
        while (bus.spi_newd === 1'b1 && cnt < 4 * NEWD_HOLD) begin
            if (early) bus.spi_done = (cnt >= 4 && cnt < 8);
            cnt++;
            @(negedge clk);
        end
        bus.spi_done = 1'b0;
        chk("newd_len", cnt, NEWD_HOLD);
        if (drop_mid) bus.req[k] = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (bus.ack !== '0) bad = 1'b1;
            @(negedge clk);
        end
        bus.spi_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.ack !== '0) bad = 1'b1;
        end
        @(negedge clk);
        chk("no_early_ack", bad, 0);
        chk("ack", bus.ack, 32'(1) << k);
        chk("din_held", bus.spi_din, word);
        chk("timeout_err_low", bus.timeout_err, 0);
        bus.req[k] = 1'b0;
        mptr = (k + 1) % NREQ;
        @(negedge clk);
        bus.spi_done = 1'b0;
        chk("idle_busy", bus.busy, 0);
        chk("idle_ack", bus.ack, 0);
        chk("idle_gnt", bus.gnt, 0);
        chk("din_after", bus.spi_din, word);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mptr = 0;
    endtask

    initial begin
        int k;
        int cnt;
        rst          = 1'b1;
        bus.req      = '0;
        bus.spi_done = 1'b0;
        for (int i = 0; i < NREQ; i++) data[i] = '0;
        drive_data();
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_newd", bus.spi_newd, 0);
        chk("rst_din", bus.spi_din, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_toerr", bus.timeout_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, with a spurious done pulse during LAUNCH.
        data[0] = 12'hA5C;
        drive_data();
        bus.req = 4'b0001;
        txn(4, 1'b0, 1'b1, k);
        chk("single_k", k, 0);
        repeat (3) @(negedge clk);
        chk("single_quiet", bus.busy, 0);

        // All four at once from a fresh pointer.
        do_reset();
        data[0] = 12'h111;
        data[1] = 12'h222;
        data[2] = 12'h333;
        data[3] = 12'h444;
        drive_data();
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            txn(i + 1, 1'b0, 1'b0, k);
            chk("order", k, i);
        end

        // Fairness after client 2.
        bus.req = 4'b0100;
        txn(2, 1'b0, 1'b0, k);
        bus.req = 4'b1111;
        txn(0, 1'b0, 1'b0, k);
        chk("fair_first", k, 3);
        txn(0, 1'b0, 1'b0, k);
        chk("fair_second", k, 0);
        while (bus.req != '0) txn(1, 1'b0, 1'b0, k);

        // Request dropped during WAIT still completes, no regrant.
        bus.req = 4'b0010;
        txn(5, 1'b1, 1'b0, k);
        chk("drop_k", k, 1);
        repeat (4) @(negedge clk);
        chk("drop_no_regrant", bus.gnt, 0);

        // Random traffic.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && ($urandom_range(0, 2) == 0)) begin
                    data[i]    = DW'($urandom);
                    bus.req[i] = 1'b1;
                end
            end
            drive_data();
            if (bus.req == '0) bus.req[$urandom_range(0, NREQ-1)] = 1'b1;
            txn($urandom_range(0, 12), ($urandom_range(0, 4) == 0),
                $urandom_range(0, 1) == 1, k);
        end
        while (bus.req != '0) txn(0, 1'b0, 1'b0, k);

        // Reset during LAUNCH with a non-zero pointer.
        bus.req = 4'b0001;
        txn(1, 1'b0, 1'b0, k);
        bus.req = 4'b1111;
        @(negedge clk);
        chk("pre_rst_gnt", bus.gnt, 4'b0010);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", bus.gnt, 0);
        chk("mid_rst_newd", bus.spi_newd, 0);
        chk("mid_rst_din", bus.spi_din, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(negedge clk);
        chk("mid_rst_ack", bus.ack, 0);
        rst  = 1'b0;
        mptr = 0;
        txn(2, 1'b0, 1'b0, k);
        chk("post_rst_k", k, 0);
        while (bus.req != '0) txn(0, 1'b0, 1'b0, k);

`ifdef SPI_ARB_TIMEOUT_EN
        // Link never answers: abort after TIMEOUT cycles in WAIT.
        bus.req = 4'b0100;
        @(negedge clk);
        chk("to_gnt", bus.gnt, 4'b0100);
        cnt = 0;
        while (bus.spi_newd === 1'b1 && cnt < 4 * NEWD_HOLD) begin
            cnt++;
            @(negedge clk);
        end
        cnt = 0;
        while (bus.ack === '0 && cnt < 2 * TIMEOUT) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_latency", cnt, TIMEOUT);
        chk("to_ack", bus.ack, 4'b0100);
        chk("to_err", bus.timeout_err, 1);
        bus.req = '0;
        @(negedge clk);
        chk("to_idle", bus.busy, 0);
        chk("to_err_pulse", bus.timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
